// File: rtl/qed_dup_scheduler.sv
// QED original/duplicate batch sequencer: counts originals, replays as many duplicates, drains, then pulses qed_ready.
// Optional macro QED_NONDET_SWITCH_EN adds i_dup_req for an early ORIG->DUP switch.
module qed_dup_scheduler #(
    parameter int unsigned MAX_BLOCK = 16,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic             i_stall_if,
    input  logic             i_vld_out,
    input  logic             i_pipe_empty,
`ifdef QED_NONDET_SWITCH_EN
    input  logic             i_dup_req,
`endif
    output logic             o_exec_dup,
    output logic             o_qed_ready,
    output logic [CNT_W-1:0] o_orig_cnt,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0]   MaxBlk   = CNT_W'(MAX_BLOCK);
    localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
    localparam logic [DRAIN_W-1:0] DrainMax = DRAIN_W'(DRAIN_MAX);
    localparam logic [DRAIN_W-1:0] DrainOne = DRAIN_W'(1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StOrig  = 3'd1,
        StDup   = 3'd2,
        StDrain = 3'd3,
        StCheck = 3'd4
    } state_e;

    state_e             r_state, w_state_d;
    logic [CNT_W-1:0]   r_orig_cnt, w_orig_cnt_d;
    logic [CNT_W-1:0]   r_dup_cnt, w_dup_cnt_d;
    logic [DRAIN_W-1:0] r_drain_cnt, w_drain_cnt_d;
    logic               r_err, w_err_d;
    logic               r_exec_dup, r_qed_ready, r_busy;
    logic               w_early;

`ifdef QED_NONDET_SWITCH_EN
    assign w_early = i_dup_req;
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_orig_cnt_d  = r_orig_cnt;
        w_dup_cnt_d   = r_dup_cnt;
        w_drain_cnt_d = r_drain_cnt;
        w_err_d       = r_err;
        unique case (r_state)
            StIdle: begin
                if (i_ena) w_state_d = StOrig;
            end
            StOrig: begin
                // Dropping ena closes the batch; no fetch is counted in that cycle.
                if (!i_ena) begin
                    w_state_d = (r_orig_cnt == '0) ? StIdle : StDup;
                end else if (w_early && (r_orig_cnt != '0)) begin
                    w_state_d = StDup;
                end else if (!i_stall_if && (r_orig_cnt != MaxBlk)) begin
                    w_orig_cnt_d = r_orig_cnt + CntOne;
                    if (w_orig_cnt_d == MaxBlk) w_state_d = StDup;
                end
            end
            StDup: begin
                if (!i_stall_if && i_vld_out && (r_dup_cnt != r_orig_cnt)) begin
                    w_dup_cnt_d = r_dup_cnt + CntOne;
                    if (w_dup_cnt_d == r_orig_cnt) w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_drain_cnt != DrainMax) w_drain_cnt_d = r_drain_cnt + DrainOne;
                if (i_pipe_empty) begin
                    w_state_d = StCheck;
                end else if (w_drain_cnt_d == DrainMax) begin
                    w_err_d   = 1'b1;
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                w_orig_cnt_d  = '0;
                w_dup_cnt_d   = '0;
                w_drain_cnt_d = '0;
                w_state_d     = i_ena ? StOrig : StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_orig_cnt  <= '0;
            r_dup_cnt   <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
            r_exec_dup  <= 1'b0;
            r_qed_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_orig_cnt  <= w_orig_cnt_d;
            r_dup_cnt   <= w_dup_cnt_d;
            r_drain_cnt <= w_drain_cnt_d;
            r_err       <= w_err_d;
            // Flag outputs are flopped from the next state so they align with it.
            r_exec_dup  <= (w_state_d == StDup);
            r_qed_ready <= (w_state_d == StCheck);
            r_busy      <= (w_state_d != StIdle);
        end
    end

    assign o_exec_dup  = r_exec_dup;
    assign o_qed_ready = r_qed_ready;
    assign o_orig_cnt  = r_orig_cnt;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule
